// File: rtl/write_back.sv
// rtl/write_back.sv - commit stage: owns PC, int/float register files and retire counter
module write_back #(
    parameter logic [31:0] RESET_PC          = 32'h0,
    parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        exec_done,
    input  logic [2:0]  wselector,
    input  logic [4:0]  rd,
    input  logic [31:0] data,
    input  logic [31:0] pc_in,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        fetch_enable,
    input  logic [4:0]  rs_no,
    input  logic [4:0]  rt_no,
    input  logic        fmode1,
    input  logic        fmode2,
    output logic [31:0] rs_val,
    output logic [31:0] rt_val,
    output logic [31:0] retired,
    output logic        halted,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        perr_q, perr_d;
    logic [31:0] int_rf_q [32];
    logic [31:0] fp_rf_q  [32];

    logic        commit;
    logic        wr_int;
    logic        wr_fp;
    logic [31:0] target;
    logic        self_jump;

    // Branch targets are forced to word alignment; a jump to the current PC is a halt request.
    assign target    = pc_in & ~32'h3;
    assign self_jump = HALT_ON_SELF_JUMP && wselector[2] && (target == pc_q);

    // A commit only counts in WAIT; a stalled commit writes nothing. Int r0 is never written.
    assign commit = (state_q == ST_WAIT) && exec_done;
    assign wr_int = commit && !stall && wselector[1] && !wselector[0] && (rd != 5'd0);
    assign wr_fp  = commit && !stall && wselector[1] &&  wselector[0];

    // Next-state logic for the sequencer, PC, retire counter and protocol error flag.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        perr_d    = perr_q;
        case (state_q)
            ST_START: state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (exec_done) begin
                    if (stall) begin
                        state_d = ST_ISSUE;
                    end else begin
                        pc_d      = wselector[2] ? target : pc_q + 32'd4;
                        retired_d = retired_q + 32'd1;
                        state_d   = self_jump ? ST_HALT : ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
        if (exec_done && (state_q != ST_WAIT)) begin
            perr_d = 1'b1;
        end
    end

    // Sequencer and architectural scalar state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_START;
            pc_q      <= RESET_PC;
            retired_q <= 32'h0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            perr_q    <= perr_d;
        end
    end

    // Integer and float register files, cleared on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                int_rf_q[i] <= 32'h0;
                fp_rf_q[i]  <= 32'h0;
            end
        end else begin
            if (wr_int) begin
                int_rf_q[rd] <= data;
            end
            if (wr_fp) begin
                fp_rf_q[rd] <= data;
            end
        end
    end

    // rs read port: a same-cycle commit to the addressed register is forwarded.
    always_comb begin
        rs_val = 32'h0;
        if (fmode1) begin
            rs_val = (wr_fp && rd == rs_no) ? data : fp_rf_q[rs_no];
        end else if (rs_no != 5'd0) begin
            rs_val = (wr_int && rd == rs_no) ? data : int_rf_q[rs_no];
        end
    end

    // rt read port: same rules as rs.
    always_comb begin
        rt_val = 32'h0;
        if (fmode2) begin
            rt_val = (wr_fp && rd == rt_no) ? data : fp_rf_q[rt_no];
        end else if (rt_no != 5'd0) begin
            rt_val = (wr_int && rd == rt_no) ? data : int_rf_q[rt_no];
        end
    end

    assign pc           = pc_q;
    assign fetch_enable = (state_q == ST_ISSUE);
    assign retired      = retired_q;
    assign halted       = (state_q == ST_HALT);
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - randomized and directed checks of write_back against a reference model
module tb_write_back;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exec_done;
    logic [2:0]  wselector;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc_in;
    logic        stall;
    logic [31:0] pc;
    logic        fetch_enable;
    logic [4:0]  rs_no, rt_no;
    logic        fmode1, fmode2;
    logic [31:0] rs_val, rt_val;
    logic [31:0] retired;
    logic        halted;
    logic        protocol_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_int [32];
    logic [31:0] m_fp  [32];
    logic [31:0] m_pc;
    logic [31:0] m_retired;
    logic        m_halted;
    logic        m_perr;

    write_back dut (
        .clk(clk), .rstn(rstn), .exec_done(exec_done), .wselector(wselector),
        .rd(rd), .data(data), .pc_in(pc_in), .stall(stall), .pc(pc),
        .fetch_enable(fetch_enable), .rs_no(rs_no), .rt_no(rt_no),
        .fmode1(fmode1), .fmode2(fmode2), .rs_val(rs_val), .rt_val(rt_val),
        .retired(retired), .halted(halted), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_int[i] = 32'h0;
            m_fp[i]  = 32'h0;
        end
        m_pc = 32'h0; m_retired = 32'h0; m_halted = 1'b0; m_perr = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic f, input logic [4:0] a);
        if (f) return m_fp[a];
        return (a == 5'd0) ? 32'h0 : m_int[a];
    endfunction

    task automatic check_scalars(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_retired"}, retired, m_retired);
        chk({tag, "_halted"}, 32'(halted), 32'(m_halted));
        chk({tag, "_perr"}, 32'(protocol_err), 32'(m_perr));
    endtask

    // Enter at a negedge no later than the ISSUE cycle; leave at the negedge of cycle N+1.
    task automatic commit(input logic [2:0] sel, input logic [4:0] r, input logic [31:0] d,
                          input logic [31:0] tgt, input logic st,
                          input logic [4:0] a, input logic [4:0] b,
                          input logic fa, input logic fb);
        int n;
        logic [31:0] aligned;
        n = 0;
        while (fetch_enable !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_seen", 32'(fetch_enable), 32'h1);
        chk("pc_at_fetch", pc, m_pc);
        @(negedge clk);
        chk("fetch_single", 32'(fetch_enable), 32'h0);
        exec_done = 1'b1; wselector = sel; rd = r; data = d; pc_in = tgt; stall = st;
        rs_no = a; rt_no = b; fmode1 = fa; fmode2 = fb;
        if (!st) begin
            if (sel[1]) begin
                if (sel[0]) m_fp[r] = d;
                else m_int[r] = d;
            end
            aligned = {tgt[31:2], 2'b00};
            if (sel[2] && aligned == m_pc) m_halted = 1'b1;
            m_pc = sel[2] ? aligned : m_pc + 32'd4;
            m_retired = m_retired + 32'd1;
        end
        #1;
        chk("rs_bypass", rs_val, m_read(fa, a));
        chk("rt_bypass", rt_val, m_read(fb, b));
        @(negedge clk);
        exec_done = 1'b0; stall = 1'b0; wselector = 3'b000;
        check_scalars("post");
        chk("post_fetch", 32'(fetch_enable), 32'(!m_halted));
        chk("rs_post", rs_val, m_read(fa, a));
        chk("rt_post", rt_val, m_read(fb, b));
    endtask

    initial begin
        logic [31:0] tgt;
        logic [2:0]  sel;
        rstn = 1'b0; exec_done = 1'b0; wselector = 3'b000; rd = 5'd0; data = 32'h0;
        pc_in = 32'h0; stall = 1'b0; rs_no = 5'd0; rt_no = 5'd0; fmode1 = 1'b0; fmode2 = 1'b0;
        model_reset();
        #12;
        check_scalars("reset");
        chk("reset_fetch", 32'(fetch_enable), 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs_no = 5'(i); rt_no = 5'(i); fmode1 = 1'b0; fmode2 = 1'b1;
            #1;
            chk("reset_int_rd", rs_val, 32'h0);
            chk("reset_fp_rd", rt_val, 32'h0);
        end

        @(posedge clk); #1 rstn = 1'b1;
        chk("start_no_fetch", 32'(fetch_enable), 32'h0);
        @(posedge clk); #1;
        chk("first_fetch", 32'(fetch_enable), 32'h1);
        chk("first_pc", pc, 32'h0);
        @(negedge clk);

        commit(3'b010, 5'd5, 32'h1234, 32'h0, 1'b0, 5'd5, 5'd5, 1'b0, 1'b1);
        commit(3'b011, 5'd0, 32'h3F800000, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
        commit(3'b010, 5'd0, 32'hCAFEF00D, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        commit(3'b110, 5'd31, 32'h8, 32'h103, 1'b0, 5'd31, 5'd31, 1'b0, 1'b1);
        commit(3'b010, 5'd9, 32'hDEAD, 32'h0, 1'b1, 5'd9, 5'd31, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            tgt = $urandom;
            if ({tgt[31:2], 2'b00} == m_pc) tgt = tgt ^ 32'h10;
            sel = 3'($urandom);
            commit(sel, 5'($urandom), $urandom, tgt, ($urandom_range(0, 7) == 0),
                   5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        end

        if (m_pc == 32'hFFFFFFFC) commit(3'b000, 5'd0, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0);
        commit(3'b100, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1);
        commit(3'b000, 5'd0, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b1);
        chk("wrap_pc", pc, 32'h0);
        commit(3'b100, 5'd0, 32'h0, 32'h0, 1'b0, 5'd1, 5'd2, 1'b1, 1'b0);
        chk("halted_set", 32'(halted), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_no_fetch", 32'(fetch_enable), 32'h0);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        m_perr = 1'b1;
        check_scalars("halt_exec");

        rstn = 1'b0;
        model_reset();
        #1;
        check_scalars("rst2");
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        commit(3'b010, 5'd7, 32'h77, 32'h0, 1'b0, 5'd7, 5'd7, 1'b0, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        rs_no = 5'd7; fmode1 = 1'b0;
        #0;
        check_scalars("midwait_rst");
        chk("midwait_fetch", 32'(fetch_enable), 32'h0);
        #1;
        chk("midwait_rf_cleared", rs_val, 32'h0);
        @(posedge clk); #1 rstn = 1'b1; exec_done = 1'b1;
        @(posedge clk); #1 exec_done = 1'b0;
        m_perr = 1'b1;
        check_scalars("start_exec");
        chk("start_exec_fetch", 32'(fetch_enable), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
